// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access sizes, FSM states and lane count.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    CLEAR
  } state_e;

  localparam int LANES = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction plus
// sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       offset,
  input  logic             is_unsigned,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] byte_en,
  output logic [31:0]      wdata_lanes,
  output logic [31:0]      rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    byte_en     = '0;
    wdata_lanes = '0;
    rdata_ext   = '0;
    rbyte       = rword[8*offset +: 8];
    rhalf       = offset[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_WORD: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable data memory with valid/ready requests, WAIT_STATES latency
// and a registered response. Define DMEM_CLEAR_ON_RESET_EN to zero the array after reset.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_e            state, state_next;
  logic [2:0]        count, count_next;
  logic              accept, commit;
  logic              cap_write, cap_unsigned;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              op_write, op_unsigned;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              err;
  logic [LANES-1:0]  byte_en;
  logic [31:0]       wdata_lanes, rdata_ext, rword;
  logic              clear_we;
  logic [IDX_W-1:0]  clear_idx;
  logic [31:0]       mem [DEPTH];

  assign req_ready = (state == IDLE) || (state == RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_next == RESP) && !reset;

  // With no wait states the commit edge is the accept edge, so the live
  // request fields are used before they land in the capture registers.
  assign op_write    = (WAIT_STATES == 0) ? req_write    : cap_write;
  assign op_size     = (WAIT_STATES == 0) ? req_size     : cap_size;
  assign op_unsigned = (WAIT_STATES == 0) ? req_unsigned : cap_unsigned;
  assign op_addr     = (WAIT_STATES == 0) ? req_addr     : cap_addr;
  assign op_wdata    = (WAIT_STATES == 0) ? req_wdata    : cap_wdata;

  assign word_idx = op_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign err = (op_size == 2'b11)
            || (op_size == SZ_HALF && op_addr[0])
            || (op_size == SZ_WORD && op_addr[1:0] != 2'b00)
            || (word_idx >= (ADDR_W-2)'(DEPTH));
  assign rword = mem[mem_idx];

  dmem_lane_align u_align (
    .size        (op_size),
    .offset      (op_addr[1:0]),
    .is_unsigned (op_unsigned),
    .wdata       (op_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = WS_INIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (count == 3'd0) state_next = RESP;
        else count_next = count - 3'd1;
      end
      CLEAR: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (clear_idx == IDX_W'(DEPTH - 1)) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      resp_valid <= commit;
      resp_err   <= commit && err;
      resp_rdata <= (commit && !op_write && !err) ? rdata_ext : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write    <= req_write;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  assign clear_we = (state == CLEAR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) clear_idx <= '0;
    else if (clear_we) clear_idx <= clear_idx + 1'b1;
  end
`else
  assign clear_we  = 1'b0;
  assign clear_idx = '0;
`endif

  // Array has no reset; only the byte lanes enabled by the access change.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_idx] <= 32'h0;
    end else if (commit && op_write && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

endmodule
